// File: rtl/pri_decoder.sv
// Two-stage valid/ready decoder: leading-zero count -> normalized one-hot (inverse of the leading-one encoder).
// Define PRI_DECODER_THERM_EN to add the registered thermometer mask output out_mask.
module pri_decoder #(
  parameter int WIDTH     = 106,
  parameter int WIDTH_LOG = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_LOG-1:0] in_shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_vec,
  output logic [WIDTH_LOG-1:0] out_msb,
  output logic                 out_zero,
  output logic                 out_err
`ifdef PRI_DECODER_THERM_EN
  ,
  output logic [WIDTH-1:0]     out_mask
`endif
);

  localparam int                   PADW    = 1 << WIDTH_LOG;
  localparam logic [WIDTH_LOG:0]   WIDTH_X = (WIDTH_LOG+1)'(WIDTH);
  localparam logic [WIDTH_LOG-1:0] TOP_IDX = WIDTH_LOG'(WIDTH - 1);

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_ERR
  } cls_e;

  logic                 s1_adv, s2_adv;
  logic                 s1_valid_d, s1_valid_q;
  cls_e                 s1_cls_d, s1_cls_q;
  logic [WIDTH_LOG-1:0] s1_idx_d, s1_idx_q;
  logic                 s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0]     out_vec_d, out_vec_q;
  logic [WIDTH_LOG-1:0] out_msb_d, out_msb_q;
  logic                 out_zero_d, out_zero_q;
  logic                 out_err_d, out_err_q;
  logic [PADW-1:0]      tree_cur, tree_nxt;
  logic [WIDTH-1:0]     dec_onehot;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready = s1_adv;

  // Range checks run one bit wider than in_shift so the all-ones shift cannot wrap into range.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cls_d   = s1_cls_q;
    s1_idx_d   = s1_idx_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        if ({1'b0, in_shift} > WIDTH_X)       s1_cls_d = CLS_ERR;
        else if ({1'b0, in_shift} == WIDTH_X) s1_cls_d = CLS_ZERO;
        else                                  s1_cls_d = CLS_NORMAL;
        s1_idx_d = TOP_IDX - in_shift;
      end
    end
  end

  // Binary decode tree: each level splits every live node by the next idx bit, MSB first.
  always_comb begin
    tree_cur    = '0;
    tree_cur[0] = 1'b1;
    tree_nxt    = '0;
    for (int unsigned lvl = 0; lvl < WIDTH_LOG; lvl++) begin
      tree_nxt = '0;
      for (int unsigned j = 0; j < (32'd1 << lvl); j++) begin
        tree_nxt[2*j+1] = tree_cur[j] &  s1_idx_q[WIDTH_LOG-1-lvl];
        tree_nxt[2*j]   = tree_cur[j] & ~s1_idx_q[WIDTH_LOG-1-lvl];
      end
      tree_cur = tree_nxt;
    end
    dec_onehot = tree_cur[WIDTH-1:0];
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_vec_d  = out_vec_q;
    out_msb_d  = out_msb_q;
    out_zero_d = out_zero_q;
    out_err_d  = out_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_vec_d  = (s1_cls_q == CLS_NORMAL) ? dec_onehot : '0;
        out_msb_d  = (s1_cls_q == CLS_NORMAL) ? s1_idx_q : '0;
        out_zero_d = (s1_cls_q == CLS_ZERO);
        out_err_d  = (s1_cls_q == CLS_ERR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_NORMAL;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      out_vec_q  <= '0;
      out_msb_q  <= '0;
      out_zero_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cls_q   <= s1_cls_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      out_vec_q  <= out_vec_d;
      out_msb_q  <= out_msb_d;
      out_zero_q <= out_zero_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_vec   = out_vec_q;
  assign out_msb   = out_msb_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;

`ifdef PRI_DECODER_THERM_EN
  logic [WIDTH-1:0] out_mask_d, out_mask_q;
  logic [WIDTH-1:0] therm;
  logic             therm_acc;

  // Thermometer: bit k is set when the one-hot bit sits at or above k.
  always_comb begin
    therm     = '0;
    therm_acc = 1'b0;
    for (int unsigned k = WIDTH; k > 0; k--) begin
      therm_acc  = therm_acc | dec_onehot[k-1];
      therm[k-1] = therm_acc;
    end
    out_mask_d = out_mask_q;
    if (s2_adv && s1_valid_q) begin
      out_mask_d = (s1_cls_q == CLS_NORMAL) ? therm : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_mask_q <= '0;
    else     out_mask_q <= out_mask_d;
  end

  assign out_mask = out_mask_q;
`else
  // Without the thermometer option the one-hot path stands alone.
`endif

  assert property (@(posedge clk) disable iff (rst)
    out_valid |-> ($countones(out_vec) == ((out_zero || out_err) ? 0 : 1)));
  assert property (@(posedge clk) disable iff (rst) !(out_zero && out_err));

endmodule

// File: tb/tb_pri_decoder.sv
// Directed bench for pri_decoder: table of decode vectors plus streaming, backpressure, reset and round-trip sequences.
module tb_pri_decoder;
  localparam int W  = 106;
  localparam int WL = 7;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_vec;
  logic [WL-1:0] out_msb;
  logic          out_zero;
  logic          out_err;
`ifdef PRI_DECODER_THERM_EN
  logic [W-1:0]  out_mask;
`endif

  pri_decoder #(.WIDTH(W), .WIDTH_LOG(WL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_msb   (out_msb),
    .out_zero  (out_zero),
    .out_err   (out_err)
`ifdef PRI_DECODER_THERM_EN
    ,
    .out_mask  (out_mask)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [WL-1:0] shift;
    int            exp_bit;
    logic          exp_zero;
    logic          exp_err;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            n_in   = 0;
  int            n_out  = 0;
  bit            stream_chk = 1'b0;
  bit            rt_en      = 1'b0;
  logic [WL-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_pack(input logic [WL-1:0] s);
    logic [W-1:0]  v;
    logic [WL-1:0] m;
    int            si;
    si = int'(s);
    v  = '0;
    m  = '0;
    if (si < W) begin
      v[W-1-si] = 1'b1;
      m         = WL'(W-1-si);
    end
    return {13'd0, v, m, (si == W), (si > W)};
  endfunction

  function automatic logic [W-1:0] exp_mask(input logic [WL-1:0] s);
    logic [W-1:0] mk;
    mk = '0;
    for (int i = 0; i < W; i++) if (int'(s) < W && i <= W-1-int'(s)) mk[i] = 1'b1;
    return mk;
  endfunction

  // Reference leading-one encoder: leading-zero count, W for an all-zero vector.
  function automatic int lzc(input logic [W-1:0] v);
    for (int i = W-1; i >= 0; i--) if (v[i]) return W-1-i;
    return W;
  endfunction

  function automatic logic [127:0] act_pack();
    return {13'd0, out_vec, out_msb, out_zero, out_err};
  endfunction

  task automatic step();
    logic [WL-1:0] s;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_output actual=%h expected=none", act_pack());
      end else begin
        s = exp_q.pop_front();
        check("sb_out", act_pack(), exp_pack(s));
`ifdef PRI_DECODER_THERM_EN
        check("sb_mask", 128'(out_mask), 128'(exp_mask(s)));
`endif
        if (rt_en) check("round_trip", 128'(lzc(out_vec)), 128'(s));
      end
    end
    if (stream_chk) check("stream_in_ready", 128'(in_ready), 128'(1));
    if (in_valid && in_ready) begin
      exp_q.push_back(in_shift);
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t          tbl[8];
  logic [WL-1:0] bp_sh[3];
  int            k;
  int            prev;
  int            base;
  logic [W-1:0]  ev;

  initial begin
    tbl[0] = '{7'd0,   105, 1'b0, 1'b0};
    tbl[1] = '{7'd52,  53,  1'b0, 1'b0};
    tbl[2] = '{7'd105, 0,   1'b0, 1'b0};
    tbl[3] = '{7'd106, -1,  1'b1, 1'b0};
    tbl[4] = '{7'd107, -1,  1'b0, 1'b1};
    tbl[5] = '{7'd127, -1,  1'b0, 1'b1};
    tbl[6] = '{7'd1,   104, 1'b0, 1'b0};
    tbl[7] = '{7'd100, 5,   1'b0, 1'b0};
    bp_sh[0] = 7'd20;
    bp_sh[1] = 7'd30;
    bp_sh[2] = 7'd40;

    rst = 1'b1; in_valid = 1'b0; in_shift = '0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_vec",   128'(out_vec),   128'(0));
    check("rst_out_msb",   128'(out_msb),   128'(0));
    check("rst_zero_err",  128'({out_zero, out_err}), 128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
`ifdef PRI_DECODER_THERM_EN
    check("rst_out_mask",  128'(out_mask),  128'(0));
`endif

    // Table: one request at a time, latency and decoded fields.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_shift = tbl[i].shift;
      step();
      in_valid = 1'b0;
      check("lat_cycle1_valid", 128'(out_valid), 128'(0));
      step();
      ev = '0;
      if (tbl[i].exp_bit >= 0) ev[tbl[i].exp_bit] = 1'b1;
      check("tbl_valid", 128'(out_valid), 128'(1));
      check("tbl_vec",   128'(out_vec),   128'(ev));
      check("tbl_msb",   128'(out_msb),   128'((tbl[i].exp_bit >= 0) ? tbl[i].exp_bit : 0));
      check("tbl_zero",  128'(out_zero),  128'(tbl[i].exp_zero));
      check("tbl_err",   128'(out_err),   128'(tbl[i].exp_err));
`ifdef PRI_DECODER_THERM_EN
      if (tbl[i].shift == 7'd100) check("mask_100", 128'(out_mask), 128'(6'b111111));
`endif
    end
    step();

    // Streaming: 50 back-to-back requests.
    base = n_out;
    stream_chk = 1'b1;
    for (int c = 0; c < 50; c++) begin
      in_valid = 1'b1;
      in_shift = WL'((c * 7) % 128);
      step();
    end
    stream_chk = 1'b0;
    in_valid = 1'b0;
    check("stream_out_in_loop", 128'(n_out - base), 128'(48));
    repeat (3) step();
    check("stream_out_total", 128'(n_out - base), 128'(50));

    // Backpressure: 3 requests offered while out_ready is low for 5 cycles.
    base = n_out;
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_shift = bp_sh[k];
      prev = n_in;
      step();
      if (n_in != prev) k++;
      if (c >= 2) begin
        check("bp_in_ready_low", 128'(in_ready), 128'(0));
        check("bp_out_valid",    128'(out_valid), 128'(1));
        check("bp_out_stable",   act_pack(), exp_pack(bp_sh[0]));
      end
    end
    check("bp_accepted", 128'(k), 128'(2));
    out_ready = 1'b1;
    in_shift = bp_sh[k];
    prev = n_in;
    step();
    if (n_in != prev) k++;
    in_valid = 1'b0;
    check("bp_release_accept", 128'(k), 128'(3));
    repeat (4) step();
    check("bp_out_total", 128'(n_out - base), 128'(3));

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_shift = 7'd1;
    step();
    in_shift = 7'd2;
    step();
    in_valid = 1'b0;
    #1;
    check("full_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready",  128'(in_ready),  128'(1));
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_shift = 7'd10;
    step();
    in_valid = 1'b0;
    check("post_rst_lat1", 128'(out_valid), 128'(0));
    step();
    ev = '0;
    ev[95] = 1'b1;
    check("post_rst_valid", 128'(out_valid), 128'(1));
    check("post_rst_vec",   128'(out_vec),   128'(ev));
    check("post_rst_msb",   128'(out_msb),   128'(95));
    step();

    // Round trip through the reference encoder for every shift 0..106.
    rt_en = 1'b1;
    for (int s = 0; s <= W; s++) begin
      in_valid = 1'b1;
      in_shift = WL'(s);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    rt_en = 1'b0;

    check("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
